// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - two-requester round-robin RMII transmit arbiter with preamble and IFG
module eth_tx_arbiter #(
    parameter int CLK_DIV    = 4,
    parameter int IFG_DIBITS = 48
) (
    input  logic       clk_200_mhz,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       tx_e,
    output logic [1:0] tx_d,
    output logic [1:0] grant,
    output logic       underrun
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(IFG_DIBITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IFG_END = IW'(IFG_DIBITS - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_IFG      = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] slot_cnt;
    logic [4:0]    pre_cnt;
    logic [1:0]    dib_cnt;
    logic [5:0]    shift;
    logic          last_seen;
    logic [IW-1:0] ifg_cnt;
    logic          rr_prio;

    logic       tick;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       byte_start;
    logic       take;
    logic       pick1;

    assign tick       = (slot_cnt == CNT_MAX);
    assign sel_valid  = grant[1] ? s1_valid : s0_valid;
    assign sel_data   = grant[1] ? s1_data  : s0_data;
    assign sel_last   = grant[1] ? s1_last  : s0_last;
    assign byte_start = tick && (state == ST_DATA) && (dib_cnt == 2'd0) && !last_seen;
    assign take       = byte_start && sel_valid;
    assign s0_ready   = !rst && take && grant[0];
    assign s1_ready   = !rst && take && grant[1];
    // rr_prio names the requester that wins a tie; it flips away from each winner
    assign pick1      = s1_valid && (!s0_valid || rr_prio);

    always_ff @(posedge clk_200_mhz) begin
        if (rst) begin
            state     <= ST_IDLE;
            slot_cnt  <= '0;
            pre_cnt   <= '0;
            dib_cnt   <= '0;
            shift     <= '0;
            last_seen <= 1'b0;
            ifg_cnt   <= '0;
            rr_prio   <= 1'b0;
            tx_e      <= 1'b0;
            tx_d      <= 2'b00;
            grant     <= 2'b00;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            slot_cnt <= tick ? '0 : slot_cnt + CW'(1);
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (s0_valid || s1_valid) begin
                            grant   <= pick1 ? 2'b10 : 2'b01;
                            rr_prio <= !pick1;
                            tx_e    <= 1'b1;
                            tx_d    <= 2'b01;
                            pre_cnt <= 5'd1;
                            state   <= ST_PREAMBLE;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (pre_cnt == 5'd31) begin
                            tx_d      <= 2'b11;
                            dib_cnt   <= 2'd0;
                            last_seen <= 1'b0;
                            state     <= ST_DATA;
                        end else begin
                            tx_d    <= 2'b01;
                            pre_cnt <= pre_cnt + 5'd1;
                        end
                    end
                    ST_DATA: begin
                        if (dib_cnt == 2'd0) begin
                            if (!last_seen && sel_valid) begin
                                tx_d      <= sel_data[1:0];
                                shift     <= sel_data[7:2];
                                last_seen <= sel_last;
                                dib_cnt   <= 2'd1;
                            end else begin
                                // either the last byte has fully gone out or the owner starved us
                                underrun <= !last_seen;
                                tx_e     <= 1'b0;
                                tx_d     <= 2'b00;
                                grant    <= 2'b00;
                                ifg_cnt  <= IW'(1);
                                state    <= ST_IFG;
                            end
                        end else begin
                            tx_d    <= shift[1:0];
                            shift   <= {2'b00, shift[5:2]};
                            dib_cnt <= dib_cnt + 2'd1;
                        end
                    end
                    default: begin
                        // leave one tick early so the first IDLE tick lands on slot IFG_DIBITS+1
                        if (ifg_cnt >= IFG_END) begin
                            state <= ST_IDLE;
                        end else begin
                            ifg_cnt <= ifg_cnt + IW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - directed table-driven bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

    localparam int CLK_DIV    = 4;
    localparam int IFG_DIBITS = 48;

    logic       clk;
    logic       rst;
    logic       s0_valid, s0_last, s0_ready;
    logic [7:0] s0_data;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] s1_data;
    logic       tx_e;
    logic [1:0] tx_d;
    logic [1:0] grant;
    logic       underrun;

    eth_tx_arbiter #(.CLK_DIV(CLK_DIV), .IFG_DIBITS(IFG_DIBITS)) dut (
        .clk_200_mhz(clk),
        .rst        (rst),
        .s0_valid   (s0_valid),
        .s0_data    (s0_data),
        .s0_last    (s0_last),
        .s0_ready   (s0_ready),
        .s1_valid   (s1_valid),
        .s1_data    (s1_data),
        .s1_last    (s1_last),
        .s1_ready   (s1_ready),
        .tx_e       (tx_e),
        .tx_d       (tx_d),
        .grant      (grant),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int phase;
    always @(posedge clk) begin
        if (rst) phase <= 0;
        else     phase <= (phase == CLK_DIV - 1) ? 0 : phase + 1;
    end

    typedef struct {
        int          req;
        int          n;
        logic [7:0]  b0, b1, b2;
        logic [23:0] exp_d;
        int          exp_high;
        logic [1:0]  exp_g;
    } vec_t;

    vec_t       tbl[3];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int tests = 0, failures = 0;
    int rdy_cnt0 = 0, rdy_cnt1 = 0, bad_ready = 0, und_cnt = 0;
    logic last_tick;

    function void check(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function void update_drive();
        s0_valid = q0.size() > 0;
        s0_data  = s0_valid ? q0[0][7:0] : 8'h00;
        s0_last  = s0_valid ? q0[0][8] : 1'b0;
        s1_valid = q1.size() > 0;
        s1_data  = s1_valid ? q1[0][7:0] : 8'h00;
        s1_last  = s1_valid ? q1[0][8] : 1'b0;
    endfunction

    function void load(int req, int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic end_last);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? b0 : (i == 1) ? b1 : b2;
            if (req == 0) q0.push_back({end_last && (i == n - 1), b});
            else          q1.push_back({end_last && (i == n - 1), b});
        end
        update_drive();
    endfunction

    task automatic step();
        logic r0, r1, t;
        #1;
        r0 = s0_ready;
        r1 = s1_ready;
        t  = !rst && (phase == CLK_DIV - 1);
        if ((r0 || r1) && !t) bad_ready++;
        if (r0 && r1) bad_ready++;
        @(posedge clk);
        #1;
        last_tick = t;
        if (r0) begin rdy_cnt0++; void'(q0.pop_front()); end
        if (r1) begin rdy_cnt1++; void'(q1.pop_front()); end
        if (underrun) und_cnt++;
        update_drive();
    endtask

    task automatic tick();
        do step(); while (!last_tick);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        update_drive();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int req, input int n, input logic [23:0] exp_d,
                             input logic [1:0] exp_g, input int exp_high, input int exp_wait);
        int w, high, gbad, pbad, r0s, r1s;
        logic [1:0] sd[$];
        r0s = rdy_cnt0;
        r1s = rdy_cnt1;
        w = 0;
        while (!tx_e && w < 100) begin
            tick();
            if (!tx_e) w++;
        end
        check($sformatf("%s.wait_ticks", nm), w, exp_wait);
        high = 0;
        gbad = 0;
        while (tx_e && high < 300) begin
            sd.push_back(tx_d);
            if (grant !== exp_g) gbad++;
            high++;
            tick();
        end
        check($sformatf("%s.high_ticks", nm), high, exp_high);
        check($sformatf("%s.grant_held", nm), gbad, 0);
        check($sformatf("%s.grant_after", nm), grant, 0);
        check($sformatf("%s.txd_after", nm), tx_d, 0);
        pbad = 0;
        for (int i = 0; i < 31; i++) if (i >= sd.size() || sd[i] !== 2'b01) pbad++;
        check($sformatf("%s.preamble", nm), pbad, 0);
        check($sformatf("%s.sfd", nm), (sd.size() > 31) ? int'(sd[31]) : -1, 3);
        for (int k = 0; k < 4 * n; k++)
            check($sformatf("%s.dibit%0d", nm, k), (sd.size() > 32 + k) ? int'(sd[32 + k]) : -1,
                  int'(exp_d[23 - 2 * k -: 2]));
        check($sformatf("%s.ready_owner", nm), (req == 0) ? rdy_cnt0 - r0s : rdy_cnt1 - r1s, n);
        check($sformatf("%s.ready_other", nm), (req == 0) ? rdy_cnt1 - r1s : rdy_cnt0 - r0s, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int u0, w;
        tbl[0] = '{req: 0, n: 3, b0: 8'h12, b1: 8'hF5, b2: 8'h56,
                   exp_d: 24'b10_00_01_00_01_01_11_11_10_01_01_01, exp_high: 44, exp_g: 2'b01};
        tbl[1] = '{req: 0, n: 1, b0: 8'hA5, b1: 8'h00, b2: 8'h00,
                   exp_d: 24'b01_01_10_10_00_00_00_00_00_00_00_00, exp_high: 36, exp_g: 2'b01};
        tbl[2] = '{req: 1, n: 2, b0: 8'h3C, b1: 8'h81, b2: 8'h00,
                   exp_d: 24'b00_11_11_00_01_00_00_10_00_00_00_00, exp_high: 40, exp_g: 2'b10};

        // reset state with a requester already valid
        rst = 1'b1;
        load(0, 1, 8'hA5, 8'h00, 8'h00, 1'b1);
        repeat (3) step();
        check("reset.tx_e", tx_e, 0);
        check("reset.tx_d", tx_d, 0);
        check("reset.grant", grant, 0);
        check("reset.underrun", underrun, 0);
        check("reset.s0_ready", s0_ready, 0);

        foreach (tbl[i]) begin
            do_reset();
            load(tbl[i].req, tbl[i].n, tbl[i].b0, tbl[i].b1, tbl[i].b2, 1'b1);
            run_frame($sformatf("vec%0d", i), tbl[i].req, tbl[i].n, tbl[i].exp_d,
                      tbl[i].exp_g, tbl[i].exp_high, 0);
        end

        // contention and round-robin
        do_reset();
        load(0, 1, 8'h11, 8'h00, 8'h00, 1'b1);
        load(1, 1, 8'h22, 8'h00, 8'h00, 1'b1);
        run_frame("rr_s0", 0, 1, 24'b01_00_01_00_0000_0000_0000_0000, 2'b01, 36, 0);
        load(0, 1, 8'h33, 8'h00, 8'h00, 1'b1);
        run_frame("rr_s1", 1, 1, 24'b10_00_10_00_0000_0000_0000_0000, 2'b10, 36, IFG_DIBITS - 1);
        load(1, 1, 8'h44, 8'h00, 8'h00, 1'b1);
        run_frame("rr_s0b", 0, 1, 24'b11_00_11_00_0000_0000_0000_0000, 2'b01, 36, IFG_DIBITS - 1);
        run_frame("rr_s1b", 1, 1, 24'b00_01_00_01_0000_0000_0000_0000, 2'b10, 36, IFG_DIBITS - 1);

        // underrun before byte 2, then s1 arrives during the gap
        do_reset();
        u0 = und_cnt;
        load(0, 1, 8'h12, 8'h00, 8'h00, 1'b0);
        run_frame("urun", 0, 1, 24'b10_00_01_00_0000_0000_0000_0000, 2'b01, 36, 0);
        check("urun.pulse_now", underrun, 1);
        load(1, 1, 8'h5A, 8'h00, 8'h00, 1'b1);
        run_frame("ifg_s1", 1, 1, 24'b10_10_01_01_0000_0000_0000_0000, 2'b10, 36, IFG_DIBITS - 1);
        check("urun.pulse_cycles", und_cnt - u0, 1);

        // reset in the middle of DATA
        do_reset();
        load(0, 3, 8'h12, 8'hF5, 8'h56, 1'b1);
        w = 0;
        while (!tx_e && w < 10) begin tick(); w++; end
        repeat (34) tick();
        check("mid.tx_e_before", tx_e, 1);
        rst = 1'b1;
        step();
        check("mid.tx_e", tx_e, 0);
        check("mid.tx_d", tx_d, 0);
        check("mid.grant", grant, 0);
        check("mid.s0_ready", s0_ready, 0);
        rst = 1'b0;
        q0.delete();
        load(0, 1, 8'hA5, 8'h00, 8'h00, 1'b1);
        run_frame("post_rst", 0, 1, 24'b01_01_10_10_0000_0000_0000_0000, 2'b01, 36, 0);

        check("ready_outside_byte_start", bad_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 4, clk_200_mhz cycles per RMII dibit slot (200 MHz / 4 = 50 MHz dibit rate).
REQ-002 Parameter IFG_DIBITS, default 48, inter-frame gap length in dibit slots (12 bytes).
REQ-003 clk_200_mhz  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 s0_valid  in  1  requester 0 byte available.
REQ-006 s0_data  in  8  requester 0 frame byte.
REQ-007 s0_last  in  1  s0_data is the final byte of the frame.
REQ-008 s0_ready  out  1  requester 0 byte consumed this cycle.
REQ-009 s1_valid, s1_data[7:0], s1_last in; s1_ready out: identical meaning for requester 1.
REQ-010 tx_e  out  1  RMII transmit enable.
REQ-011 tx_d  out  2  RMII transmit dibit.
REQ-012 grant  out  2  one-hot owner of the TX port; 00 when idle or in gap.
REQ-013 underrun  out  1  one-cycle pulse on frame abort.

Function
REQ-014 Slot counter runs 0..CLK_DIV-1 continuously; "tick" = cycle where counter == CLK_DIV-1; tx_e and tx_d are registered and change only on tick cycles.
REQ-015 States: IDLE, PREAMBLE, DATA, IFG; all transitions occur on ticks only.
REQ-016 IDLE: on a tick with any sX_valid high, grant the winner, enter PREAMBLE, and drive tx_e=1, tx_d=01 from that tick.
REQ-017 Arbitration: round-robin per frame; single requester wins; if both valid, the requester not granted last wins; after reset requester 0 wins a tie.
REQ-018 Grant is held constant from selection until the frame ends or aborts; no preemption.
REQ-019 PREAMBLE: 31 slots of dibit 01 then one slot of 11 (7 x 0x55 + SFD 0xD5, LSB dibit first), then DATA.
REQ-020 DATA: on each byte-start tick, sX_ready=1 for that single cycle iff granted sX_valid=1; tx_d <= sX_data[1:0]; following three ticks output [3:2], [5:4], [7:6] from an internal shift register.
REQ-021 sX_ready is never asserted outside byte-start ticks or for the non-granted requester.
REQ-022 Byte accepted with sX_last=1: after its fourth dibit, next tick drives tx_e=0, tx_d=00, clears grant, enters IFG.
REQ-023 Underrun: granted sX_valid=0 at a byte-start tick -> no ready, tx_e=0, tx_d=00, underrun=1 for one clk_200_mhz cycle, grant cleared, enter IFG; remaining bytes of that frame are the requester's responsibility.
REQ-024 IFG: tx_e=0 for IFG_DIBITS ticks, then IDLE; requests arriving in IFG wait, arbitration first evaluated on the first IDLE tick.
REQ-025 Minimum frame = 1 data byte (valid and last on first byte-start tick); no length, padding or FCS processing.
REQ-026 Latency: valid rising in IDLE -> tx_e=1 at the next tick (<= CLK_DIV cycles).

Reset
REQ-027 While rst=1: state IDLE, slot counter 0, tx_e=0, tx_d=00, grant=00, s0_ready=s1_ready=0, underrun=0, round-robin pointer selects requester 0 on tie.
REQ-028 Reset asserted mid-frame takes effect on the next clock edge with no completion of the current dibit or byte.

Verification
REQ-029 s0 frame 0x12,0xF5,0x56(last) -> 31x01, 11, then 10,00,01,00, 01,01,11,11, 10,01,01,01; tx_e high exactly 44 ticks; three s0_ready pulses.
REQ-030 s0 and s1 valid together after reset -> s0 frame, 48-tick gap, s1 frame; s0 re-requests during s1 -> s0 follows next.
REQ-031 s0 drops valid before byte 2 -> tx_e low on that tick after 36 high slots, underrun pulse, grant=00, IDLE after 48 ticks.
REQ-032 Single-byte frame 0xA5(last) -> 32 preamble/SFD slots, dibits 01,01,10,10, tx_e low next tick.
REQ-033 s1 valid raised during IFG of a s0 frame -> no tx_e until IFG complete; grant=10 on first IDLE tick.
REQ-034 rst pulsed in mid DATA -> next cycle tx_e=0, tx_d=00, grant=00, ready=0; new frame then starts cleanly with full preamble.
